// File: rtl/snake_line_sched_if.sv
// Bus bundle for snake_line_sched.
// Carries the scan request (line_start, line_y, segment positions, length,
// game_end), the pixel lookup request (pix_valid, curr_x) and every
// result/status signal.
// The master modport is the video/game side. The slave modport is the scheduler.
// Segment i of snakepos_x / snakepos_y sits at [11*i +: 11]. Segment 0 is the head.
interface snake_line_sched_if #(
  parameter int MAX_SEG = 23
);
  logic                   line_start;
  logic [10:0]            line_y;
  logic [11*MAX_SEG-1:0]  snakepos_x;
  logic [11*MAX_SEG-1:0]  snakepos_y;
  logic [5:0]             length;
  logic                   game_end;
  logic                   pix_valid;
  logic [10:0]            curr_x;
  logic                   scan_busy;
  logic                   scan_done;
  logic                   overflow;
  logic                   out_valid;
  logic                   out_hit;
  logic                   out_head;
  logic [9:0]             out_addr;

  modport master (
    output line_start, line_y, snakepos_x, snakepos_y, length, game_end,
           pix_valid, curr_x,
    input  scan_busy, scan_done, overflow, out_valid, out_hit, out_head,
           out_addr
  );

  modport slave (
    input  line_start, line_y, snakepos_x, snakepos_y, length, game_end,
           pix_valid, curr_x,
    output scan_busy, scan_done, overflow, out_valid, out_hit, out_head,
           out_addr
  );
endinterface

// File: rtl/snake_line_sched.sv
// snake_line_sched: per-scanline sprite scheduler for the snake renderer.
//
// On line_start the block scans the segments one per cycle. Every segment
// whose sprite rows cover line_y is stored in a small hit table of SLOTS
// entries. The entries are written in segment order, so slot 0 holds the
// head whenever the head is on the line.
//
// Once the scan finishes, each pixel lookup (pix_valid/curr_x) returns
// three registered results one cycle later:
//   - whether a segment covers the pixel,
//   - whether that segment is the head,
//   - the sprite ROM address.
//
// Ports:
//   clk  - clock
//   rst  - synchronous, active-low reset
//   bus  - snake_line_sched_if.slave, which carries:
//            scan request  : line_start, line_y, snakepos_x/y, length,
//                            game_end
//            pixel lookup  : pix_valid, curr_x
//            scan status   : scan_busy, scan_done, overflow
//            lookup result : out_valid, out_hit, out_head, out_addr
module snake_line_sched #(
  parameter int BLK_SIZE = 32,
  parameter int MAX_SEG  = 23,
  parameter int SLOTS    = 8
) (
  input  logic                clk,
  input  logic                rst,
  snake_line_sched_if.slave   bus
);

  localparam int ROW_W = $clog2(BLK_SIZE);
  localparam int CNT_W = $clog2(SLOTS + 1);
  localparam int IDX_W = $clog2(SLOTS);

  typedef enum logic [1:0] {IDLE, SCAN, READY} state_t;

  state_t               state;
  logic [5:0]           seg_k;
  logic [5:0]           seg_n;
  logic [10:0]          line_q;
  logic [CNT_W-1:0]     fill_cnt;
  logic [SLOTS-1:0]     slot_vld;
  logic [10:0]          slot_x    [SLOTS];
  logic                 slot_head [SLOTS];
  logic [ROW_W-1:0]     slot_row  [SLOTS];

  logic                 busy_q, done_q, ovf_q;
  logic                 vld_p1, hit_p1, head_p1;
  logic [9:0]           addr_p1;

  // A sprite edge at 'base' covers 'pos'. The compare is done at 12 bits so
  // that base + BLK_SIZE never wraps.
  function automatic logic in_span(input logic [10:0] base,
                                   input logic [10:0] pos);
    return ({1'b0, pos} >= {1'b0, base}) &&
           ({1'b0, pos} <  ({1'b0, base} + 12'(BLK_SIZE)));
  endfunction

  function automatic logic [9:0] sprite_addr(input logic [10:0]      cx,
                                             input logic [10:0]      sx,
                                             input logic [ROW_W-1:0] row);
    return 10'(cx - sx) + 10'(row) * 10'(BLK_SIZE);
  endfunction

  // ---- scan stage: select segment k and test it against the latched line
  logic [10:0] seg_x, seg_y;
  logic        seg_hit, scan_step, tbl_full, wr_en;

  always_comb begin
    seg_x = '0;
    seg_y = '0;
    for (int i = 0; i < MAX_SEG; i++) begin
      if (seg_k == 6'(i)) begin
        seg_x = bus.snakepos_x[11*i +: 11];
        seg_y = bus.snakepos_y[11*i +: 11];
      end
    end
  end

  // An empty scan (seg_n == 0) spends its single SCAN cycle without testing a segment.
  assign seg_hit   = in_span(seg_y, line_q);
  assign scan_step = (state == SCAN) && (seg_n != 6'd0);
  assign tbl_full  = (fill_cnt == CNT_W'(SLOTS));
  assign wr_en     = scan_step && seg_hit && !tbl_full;

  // The table payload carries no reset. Whether an entry is live is tracked by slot_vld.
  always_ff @(posedge clk) begin
    if (bus.line_start)
      line_q <= bus.line_y;
    if (wr_en) begin
      slot_x[fill_cnt[IDX_W-1:0]]    <= seg_x;
      slot_head[fill_cnt[IDX_W-1:0]] <= (seg_k == 6'd0);
      slot_row[fill_cnt[IDX_W-1:0]]  <= ROW_W'(line_q - seg_y);
    end
  end

  // ---- lookup stage: the lowest matching slot wins
  logic             lk_found, lk_head;
  logic [10:0]      lk_x;
  logic [ROW_W-1:0] lk_row;

  always_comb begin
    lk_found = 1'b0;
    lk_head  = 1'b0;
    lk_x     = '0;
    lk_row   = '0;
    // Walk from the top slot down, so that the lowest matching slot is written last.
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (slot_vld[i] && in_span(slot_x[i], bus.curr_x)) begin
        lk_found = 1'b1;
        lk_head  = slot_head[i];
        lk_x     = slot_x[i];
        lk_row   = slot_row[i];
      end
    end
  end

  // ---- control FSM and registered outputs (p1 = one cycle after request)
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      seg_k    <= '0;
      seg_n    <= '0;
      fill_cnt <= '0;
      slot_vld <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      vld_p1   <= 1'b0;
      hit_p1   <= 1'b0;
      head_p1  <= 1'b0;
      addr_p1  <= '0;
    end else begin
      done_q <= 1'b0;
      if (bus.line_start) begin
        // A new line always restarts the scan, including one already in progress.
        state    <= SCAN;
        seg_k    <= '0;
        seg_n    <= (bus.length > 6'(MAX_SEG)) ? 6'(MAX_SEG) : bus.length;
        fill_cnt <= '0;
        slot_vld <= '0;
        ovf_q    <= 1'b0;
        busy_q   <= 1'b1;
      end else begin
        case (state)
          SCAN: begin
            if (scan_step && seg_hit) begin
              if (tbl_full) begin
                ovf_q <= 1'b1;
              end else begin
                slot_vld[fill_cnt[IDX_W-1:0]] <= 1'b1;
                fill_cnt <= fill_cnt + 1'b1;
              end
            end
            if ((seg_n == 6'd0) || (seg_k == seg_n - 6'd1)) begin
              state  <= READY;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              seg_k <= seg_k + 6'd1;
            end
          end
          default: ;
        endcase
      end

      vld_p1 <= bus.pix_valid;
      if (bus.pix_valid) begin
        if ((state == READY) && !bus.game_end && lk_found) begin
          hit_p1  <= 1'b1;
          head_p1 <= lk_head;
          addr_p1 <= sprite_addr(bus.curr_x, lk_x, lk_row);
        end else begin
          hit_p1  <= 1'b0;
          head_p1 <= 1'b0;
          addr_p1 <= '0;
        end
      end
    end
  end

  assign bus.scan_busy = busy_q;
  assign bus.scan_done = done_q;
  assign bus.overflow  = ovf_q;
  assign bus.out_valid = vld_p1;
  assign bus.out_hit   = hit_p1;
  assign bus.out_head  = head_p1;
  assign bus.out_addr  = addr_p1;

endmodule

// File: tb/tb_snake_line_sched.sv
// Directed testbench for snake_line_sched: lookup vector tables per scene
// plus hand-written sequences for scan restart, reset and output hold.
module tb_snake_line_sched;
  localparam int MAX_SEG = 23;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  snake_line_sched_if #(.MAX_SEG(MAX_SEG)) sif ();

  snake_line_sched #(.BLK_SIZE(32), .MAX_SEG(MAX_SEG), .SLOTS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif.slave)
  );

  typedef struct {
    logic [10:0] cx;
    logic        ge;
    logic        hit;
    logic        head;
    logic [9:0]  addr;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;
  int   done_cnt = 0;

  always @(negedge clk) if (sif.scan_done === 1'b1) done_cnt++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_seg(input int i, input logic [10:0] x, input logic [10:0] y);
    sif.snakepos_x[11*i +: 11] = x;
    sif.snakepos_y[11*i +: 11] = y;
  endtask

  task automatic clear_pos();
    sif.snakepos_x = '0;
    sif.snakepos_y = '0;
  endtask

  task automatic start_scan(input logic [5:0] len, input logic [10:0] ly);
    sif.length     = len;
    sif.line_y     = ly;
    sif.line_start = 1'b1;
    tick();
    sif.line_start = 1'b0;
  endtask

  // Called on the first cycle in SCAN. Counts scan_busy cycles until scan_done.
  task automatic wait_scan(input int exp_busy, input string nm);
    int busy = 0;
    bit seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      if (sif.scan_busy === 1'b1) busy++;
      if (sif.scan_done === 1'b1) seen = 1'b1;
      else tick();
    end
    chk({nm, "_busy_cycles"}, busy, exp_busy);
    chk({nm, "_done_seen"}, 32'(seen), 1);
    tick();
    chk({nm, "_done_pulse"}, 32'(sif.scan_done), 0);
  endtask

  task automatic lookup(input logic [10:0] cx, input logic ge,
                        output logic ov, output logic oh, output logic ohd,
                        output logic [9:0] oa);
    sif.curr_x    = cx;
    sif.game_end  = ge;
    sif.pix_valid = 1'b1;
    tick();
    sif.pix_valid = 1'b0;
    sif.game_end  = 1'b0;
    ov  = sif.out_valid;
    oh  = sif.out_hit;
    ohd = sif.out_head;
    oa  = sif.out_addr;
  endtask

  task automatic run_vecs(input string tag);
    logic       ov, oh, ohd;
    logic [9:0] oa;
    foreach (vecs[i]) begin
      lookup(vecs[i].cx, vecs[i].ge, ov, oh, ohd, oa);
      chk($sformatf("%s[%0d]_valid", tag, i), 32'(ov), 1);
      chk($sformatf("%s[%0d]_hit", tag, i), 32'(oh), 32'(vecs[i].hit));
      chk($sformatf("%s[%0d]_head", tag, i), 32'(ohd), 32'(vecs[i].head));
      chk($sformatf("%s[%0d]_addr", tag, i), 32'(oa), 32'(vecs[i].addr));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ov, oh, ohd;
    logic [9:0] oa;
    int         d0;

    rst = 1'b0;
    sif.line_start = 1'b0;
    sif.line_y     = '0;
    sif.length     = '0;
    sif.game_end   = 1'b0;
    sif.pix_valid  = 1'b0;
    sif.curr_x     = '0;
    clear_pos();
    tick();
    tick();
    chk("reset_outputs",
        32'({sif.scan_busy, sif.scan_done, sif.overflow, sif.out_valid,
             sif.out_hit, sif.out_head, sif.out_addr}), 0);
    rst = 1'b1;

    // A lookup while IDLE misses but is still valid.
    lookup(11'd50, 1'b0, ov, oh, ohd, oa);
    chk("idle_lookup_valid", 32'(ov), 1);
    chk("idle_lookup_hit", 32'(oh), 0);

    // Scene 1: head (100,200), body (132,200), line 205.
    clear_pos();
    set_seg(0, 11'd100, 11'd200);
    set_seg(1, 11'd132, 11'd200);
    start_scan(6'd2, 11'd205);
    wait_scan(2, "s1");
    chk("s1_overflow", 32'(sif.overflow), 0);
    vecs = '{
      '{11'd131, 1'b0, 1'b1, 1'b1, 10'd191},
      '{11'd132, 1'b0, 1'b1, 1'b0, 10'd160},
      '{11'd164, 1'b0, 1'b0, 1'b0, 10'd0},
      '{11'd100, 1'b0, 1'b1, 1'b1, 10'd160},
      '{11'd99,  1'b0, 1'b0, 1'b0, 10'd0},
      '{11'd163, 1'b0, 1'b1, 1'b0, 10'd191},
      '{11'd131, 1'b1, 1'b0, 1'b0, 10'd0}
    };
    run_vecs("s1");

    // Changing positions while READY must not disturb the table.
    clear_pos();
    sif.length = 6'd0;
    lookup(11'd131, 1'b0, ov, oh, ohd, oa);
    chk("ready_stable_hit", 32'(oh), 1);
    chk("ready_stable_addr", 32'(oa), 191);
    // With no request, out_valid drops and the results hold.
    tick();
    chk("hold_valid", 32'(sif.out_valid), 0);
    chk("hold_hit", 32'(sif.out_hit), 1);
    chk("hold_head", 32'(sif.out_head), 1);
    chk("hold_addr", 32'(sif.out_addr), 191);

    // length = 0: a one-cycle scan that leaves the table empty.
    start_scan(6'd0, 11'd205);
    wait_scan(1, "len0");
    lookup(11'd131, 1'b0, ov, oh, ohd, oa);
    chk("len0_hit", 32'(oh), 0);

    // Scene 2: ten segments on row 0. Only 8 fit in the table.
    clear_pos();
    for (int i = 0; i < 10; i++) set_seg(i, 11'(32 * i), 11'd0);
    start_scan(6'd10, 11'd0);
    wait_scan(10, "s2");
    chk("s2_overflow", 32'(sif.overflow), 1);
    vecs = '{
      '{11'd260, 1'b0, 1'b0, 1'b0, 10'd0},
      '{11'd255, 1'b0, 1'b1, 1'b0, 10'd31},
      '{11'd0,   1'b0, 1'b1, 1'b1, 10'd0},
      '{11'd40,  1'b0, 1'b1, 1'b0, 10'd8},
      '{11'd287, 1'b0, 1'b0, 1'b0, 10'd0}
    };
    run_vecs("s2");

    // Scene 3: head and body overlap at (50,50).
    clear_pos();
    set_seg(0, 11'd50, 11'd50);
    set_seg(1, 11'd50, 11'd50);
    start_scan(6'd2, 11'd50);
    chk("ovf_cleared_on_start", 32'(sif.overflow), 0);
    wait_scan(2, "s3");
    vecs = '{
      '{11'd50, 1'b0, 1'b1, 1'b1, 10'd0},
      '{11'd50, 1'b1, 1'b0, 1'b0, 10'd0},
      '{11'd81, 1'b0, 1'b1, 1'b1, 10'd31},
      '{11'd82, 1'b0, 1'b0, 1'b0, 10'd0}
    };
    run_vecs("s3");

    // Scene 4: restart a 20-segment scan on its third cycle.
    clear_pos();
    for (int i = 0; i < 20; i++) set_seg(i, 11'(32 * i), 11'd500);
    d0 = done_cnt;
    start_scan(6'd20, 11'd0);
    tick();
    tick();
    chk("abort_busy_before", 32'(sif.scan_busy), 1);
    sif.line_start = 1'b1;
    tick();
    sif.line_start = 1'b0;
    wait_scan(20, "abort");
    chk("abort_done_count", 32'(done_cnt - d0), 1);
    chk("abort_overflow", 32'(sif.overflow), 0);
    vecs = '{
      '{11'd50, 1'b0, 1'b0, 1'b0, 10'd0},
      '{11'd0,  1'b0, 1'b0, 1'b0, 10'd0}
    };
    run_vecs("abort");

    // Scene 5: reset together with line_start during a scan.
    clear_pos();
    for (int i = 0; i < 20; i++) set_seg(i, 11'd0, 11'd500);
    set_seg(0, 11'd100, 11'd200);
    set_seg(1, 11'd132, 11'd200);
    start_scan(6'd2, 11'd205);
    wait_scan(2, "s5");
    lookup(11'd131, 1'b0, ov, oh, ohd, oa);
    chk("s5_pre_hit", 32'(oh), 1);
    start_scan(6'd20, 11'd205);
    tick();
    rst = 1'b0;
    sif.line_start = 1'b1;
    tick();
    chk("rst_mid_busy", 32'(sif.scan_busy), 0);
    chk("rst_mid_outputs",
        32'({sif.scan_done, sif.overflow, sif.out_valid, sif.out_hit,
             sif.out_head, sif.out_addr}), 0);
    rst = 1'b1;
    sif.line_start = 1'b0;
    tick();
    chk("rst_stays_idle", 32'(sif.scan_busy), 0);
    lookup(11'd131, 1'b0, ov, oh, ohd, oa);
    chk("post_rst_valid", 32'(ov), 1);
    chk("post_rst_hit", 32'(oh), 0);
    chk("post_rst_addr", 32'(oa), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/snake_line_sched.md
SNAKE_LINE_SCHED -- requirements
Module: snake_line_sched

Interface
REQ-001: Parameters, one per line: name, default, meaning.
- BLK_SIZE, 32, sprite edge in pixels (power of two)
- MAX_SEG, 23, segments carried on the position buses
- SLOTS, 8, hit-table entries per scanline
REQ-002: Ports, one per line: name, direction, width, meaning.
- clk, in, 1, clock
- rst, in, 1, synchronous active-low reset
- line_start, in, 1, one-cycle pulse that starts a scan for line_y
- line_y, in, 11, scanline to be drawn next
- snakepos_x, in, 253, segment X; segment i at [11*i +: 11]; i=0 is the head
- snakepos_y, in, 253, segment Y, same packing
- length, in, 6, live segment count
- game_end, in, 1, suppresses all hits
- pix_valid, in, 1, lookup request for curr_x
- curr_x, in, 11, pixel column
- scan_busy, out, 1, scan in progress
- scan_done, out, 1, one-cycle pulse when the scan completes
- overflow, out, 1, more than SLOTS hits on the current line
- out_valid, out, 1, lookup result valid
- out_hit, out, 1, pixel covered by a segment
- out_head, out, 1, the covering segment is the head
- out_addr, out, 10, sprite ROM address (column + row*BLK_SIZE)

Function
REQ-003: States: IDLE, SCAN, READY; the block latches line_y and N = min(length, MAX_SEG) on line_start.
REQ-004: line_start in any state clears the table and overflow and enters SCAN on the next cycle; a scan already in progress is aborted.
REQ-005: SCAN examines segment k on its k-th cycle (k = 0..N-1), one segment per cycle; N = 0 leaves SCAN after one cycle with the table empty.
REQ-006: Segment k hits when seg_y <= line_y < seg_y + BLK_SIZE, evaluated at 12 bits with no wrap-around.
REQ-007: Each hit writes the next free slot with {seg_x, k==0, row = (line_y - seg_y)[4:0]}; slots fill in ascending segment order.
REQ-008: A hit that arrives with all SLOTS slots full sets overflow and is dropped; overflow holds until the next line_start or reset.
REQ-009: After the last segment, the block pulses scan_done for one cycle and enters READY; scan_busy is high for exactly the cycles spent in SCAN.
REQ-010: Lookup latency is one cycle: out_valid equals pix_valid delayed one cycle; out_hit, out_head and out_addr are registered.
REQ-011: A slot matches when seg_x <= curr_x < seg_x + BLK_SIZE (12-bit compare); among matching slots, the lowest slot wins, so the head takes priority over body segments.
REQ-012: out_addr = (curr_x - seg_x) + row*BLK_SIZE, truncated to 10 bits; when out_hit = 0, out_addr = 0 and out_head = 0.
REQ-013: Lookups issued while not in READY, or with game_end = 1, return out_hit = 0 with out_valid still asserted.
REQ-014: When pix_valid = 0, out_valid goes to 0 and out_hit, out_head and out_addr hold their previous values.
REQ-015: Position and length inputs are sampled only during SCAN; changes while in READY do not affect the table until the next line_start.

Reset
REQ-016: On rst = 0 at a clock edge, the block enters IDLE, invalidates all slots and drives scan_busy, scan_done, overflow, out_valid, out_hit, out_head and out_addr to 0.
REQ-017: Reset overrides a simultaneous line_start, and it aborts a scan in progress.

Verification
REQ-018: Head at (100,200), body at (132,200), length=2, line_y=205, line_start -> scan_busy high 2 cycles, scan_done pulse; pix_valid with curr_x=131 -> next cycle out_hit=1, out_head=1, out_addr=191.
REQ-019: Same table, curr_x=132 -> out_hit=1, out_head=0, out_addr=160; curr_x=164 -> out_hit=0, out_addr=0.
REQ-020: Ten segments all at y=0, x=0..288 step 32, line_y=0 -> 8 slots filled, overflow=1; curr_x=260 (segment 8, which was dropped) -> out_hit=0.
REQ-021: Head and body overlapping at (50,50), line_y=50, curr_x=50 -> out_head=1 (lowest slot wins); game_end=1 on the same lookup -> out_hit=0.
REQ-022: line_start again at scan cycle 3 of a 20-segment scan -> table cleared, new scan of 20 cycles, exactly one scan_done; length=0 -> scan_done one cycle after SCAN entry, table empty.
REQ-023: rst=0 asserted mid-SCAN together with line_start -> IDLE, all outputs 0; a lookup issued next returns out_hit=0.
